fir_decim_mem_ctrl: RTL and testbench



---
 rtl/fir_decim_mem_ctrl_if.sv | 36 +++
 rtl/fir_decim_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_fir_decim_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_decim_mem_ctrl_if.sv
// Bundle of sample handshake, coefficient-load arbitration, memory control
// and accumulator strobe signals for the polyphase decimator memory controller.
interface fir_decim_mem_ctrl_if #(
  parameter int AW = 8,
  parameter int PW = 7
);
  logic          s_valid;
  logic          s_ready;
  logic          c_load;
  logic          c_busy;
  logic          sample_we;
  logic          sample_en_0;
  logic          sample_en_1;
  logic          coeff_en;
  logic [AW-1:0] sample_addr;
  logic [AW-1:0] coeff_addr;
  logic          mac_valid;
  logic          mac_first;
  logic          mac_done;
  logic [PW-1:0] phase;
  logic          overrun;

  // Handshake: a sample is accepted on a rising edge where s_valid & s_ready
  // are both high; s_ready never depends on s_valid, only on state and c_load.
  modport master (
    input  s_valid, c_load,
    output s_ready, c_busy, sample_we, sample_en_0, sample_en_1, coeff_en,
           sample_addr, coeff_addr, mac_valid, mac_first, mac_done, phase, overrun
  );

  modport slave (
    output s_valid, c_load,
    input  s_ready, c_busy, sample_we, sample_en_0, sample_en_1, coeff_en,
           sample_addr, coeff_addr, mac_valid, mac_first, mac_done, phase, overrun
  );
endinterface

// File: rtl/fir_decim_mem_ctrl.sv
// Sample/coefficient memory sequencer for the polyphase decimator.
// Optional sticky overrun detection is built when FIR_CTRL_OVERRUN_EN is defined.
module fir_decim_mem_ctrl #(
  parameter int MAC_SIZE = 255,
  parameter int D        = 100,
  parameter int AW       = $clog2(MAC_SIZE),
  parameter int PW       = $clog2(D)
) (
  input  logic                    clk,
  input  logic                    rst,
  fir_decim_mem_ctrl_if.master    bus,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_wp;
  logic          r_bank;
  logic [PW-1:0] r_phase;
  logic [AW-1:0] r_i;
  logic          r_mac_valid;
  logic          r_mac_first;
  logic          r_mac_done;

  logic          w_ready;
  logic          w_accept;
  logic          w_last_tap;
  logic          w_last_phase;
  logic [AW:0]   w_rd_sum;
  logic [AW-1:0] w_rd_addr;

  assign w_ready      = (r_state == IDLE) && !bus.c_load;
  assign w_accept     = w_ready && bus.s_valid;
  assign w_last_tap   = (r_i == AW'(MAC_SIZE - 1));
  assign w_last_phase = (r_phase == PW'(D - 1));

  // Newest-first read address (wp-1-i) mod MAC_SIZE, one extra bit so the
  // sum never wraps at 2^AW before the modular correction.
  assign w_rd_sum  = {1'b0, r_wp} + (AW+1)'(MAC_SIZE - 1) - {1'b0, r_i};
  assign w_rd_addr = (w_rd_sum >= (AW+1)'(MAC_SIZE)) ?
                     AW'(w_rd_sum - (AW+1)'(MAC_SIZE)) : AW'(w_rd_sum);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.c_load)                     w_state_nxt = LOAD;
        else if (w_accept && w_last_phase)  w_state_nxt = RUN;
      end
      RUN:   if (w_last_tap) w_state_nxt = DRAIN;
      DRAIN: w_state_nxt = IDLE;
      LOAD:  if (!bus.c_load) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready     = w_ready;
    bus.c_busy      = 1'b0;
    bus.sample_we   = 1'b0;
    bus.sample_en_0 = 1'b0;
    bus.sample_en_1 = 1'b0;
    bus.coeff_en    = 1'b0;
    bus.sample_addr = '0;
    bus.coeff_addr  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          bus.sample_we   = 1'b1;
          bus.sample_addr = r_wp;
          bus.sample_en_0 = !r_bank;
          bus.sample_en_1 = r_bank;
        end
      end
      RUN: begin
        bus.sample_en_0 = 1'b1;
        bus.sample_en_1 = 1'b1;
        bus.coeff_en    = 1'b1;
        bus.sample_addr = w_rd_addr;
        bus.coeff_addr  = r_i;
      end
      LOAD: begin
        bus.c_busy   = 1'b1;
        bus.coeff_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wp        <= '0;
      r_bank      <= 1'b0;
      r_phase     <= '0;
      r_i         <= '0;
      r_mac_valid <= 1'b0;
      r_mac_first <= 1'b0;
      r_mac_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Both banks share one write pointer; it advances once a pair is written.
      if (w_accept) begin
        r_bank  <= !r_bank;
        r_phase <= w_last_phase ? '0 : r_phase + 1'b1;
        if (r_bank) r_wp <= (r_wp == AW'(MAC_SIZE - 1)) ? '0 : r_wp + 1'b1;
      end
      if (r_state == RUN) r_i <= w_last_tap ? '0 : r_i + 1'b1;
      else                r_i <= '0;
      r_mac_valid <= (r_state == RUN);
      r_mac_first <= (r_state == RUN) && (r_i == '0);
      r_mac_done  <= (r_state == RUN) && w_last_tap;
    end
  end

`ifdef FIR_CTRL_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk) begin
    if (rst)
      r_overrun <= 1'b0;
    else if (bus.s_valid && !w_ready && (r_state != LOAD))
      r_overrun <= 1'b1;
  end

  assign bus.overrun = r_overrun;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.mac_valid = r_mac_valid;
  assign bus.mac_first = r_mac_first;
  assign bus.mac_done  = r_mac_done;
  assign bus.phase     = r_phase;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fir_decim_mem_ctrl.sv
// Self-checking bench for fir_decim_mem_ctrl with MAC_SIZE=5, D=4: queue
// scoreboard for writes, read sweeps and accumulator strobes.
module tb_fir_decim_mem_ctrl;
  localparam int MAC_SIZE = 5;
  localparam int D        = 4;
  localparam int AW       = $clog2(MAC_SIZE);
  localparam int PW       = $clog2(D);
`ifdef FIR_CTRL_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  fir_decim_mem_ctrl_if #(.AW(AW), .PW(PW)) bus ();

  fir_decim_mem_ctrl #(.MAC_SIZE(MAC_SIZE), .D(D), .AW(AW), .PW(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+1:0]   exp_wr_q[$];   // {addr, en_1, en_0}
  logic [2*AW-1:0] exp_rd_q[$];   // {sample_addr, coeff_addr}
  logic [1:0]      exp_mac_q[$];  // {mac_first, mac_done}

  int n_acc      = 0;
  int exp_frames = 0;
  int done_cnt   = 0;
  int run_len    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: accept number n goes to address n/2, bank n%2
  task automatic push_accept();
    int  wa;
    int  wp;
    bit  bk;
    wa = (n_acc / 2) % MAC_SIZE;
    bk = bit'(n_acc % 2);
    exp_wr_q.push_back({AW'(wa), bk, ~bk});
    n_acc++;
    if (n_acc % D == 0) begin
      wp = (n_acc / 2) % MAC_SIZE;
      for (int i = 0; i < MAC_SIZE; i++) begin
        int ra;
        ra = ((wp - 1 - i) % MAC_SIZE + MAC_SIZE) % MAC_SIZE;
        exp_rd_q.push_back({AW'(ra), AW'(i)});
        exp_mac_q.push_back({i == 0, i == MAC_SIZE - 1});
      end
      exp_frames++;
    end
  endtask

  // driver: holds s_valid high until n samples are accepted
  task automatic send_samples(input int n);
    int got_n;
    int wait_cyc;
    got_n    = 0;
    wait_cyc = 0;
    while (got_n < n) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      #1;
      if (bus.s_ready) begin
        check("phase_at_accept", 32'(bus.phase), 32'(n_acc % D));
        push_accept();
        got_n++;
        wait_cyc = 0;
      end else begin
        wait_cyc++;
        if (wait_cyc > 50) begin
          check("accept_timeout", 32'd0, 32'd1);
          break;
        end
      end
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    #1;
    while (!bus.s_ready && k < 30) begin
      k++;
      @(negedge clk);
      #1;
    end
    if (k >= 30) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus.sample_we) begin
        if (exp_wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else check("write", 32'({bus.sample_addr, bus.sample_en_1, bus.sample_en_0}),
                   32'(exp_wr_q.pop_front()));
      end else if (bus.sample_en_0 && bus.sample_en_1) begin
        if (exp_rd_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
        else begin
          check("read_addr", 32'({bus.sample_addr, bus.coeff_addr}), 32'(exp_rd_q.pop_front()));
          check("read_coeff_en", 32'(bus.coeff_en), 32'd1);
        end
      end
      if (bus.mac_valid) begin
        if (bus.mac_first) run_len = 0;
        run_len++;
        if (exp_mac_q.size() == 0) check("unexpected_mac", 32'd1, 32'd0);
        else check("mac_strobes", 32'({bus.mac_first, bus.mac_done}), 32'(exp_mac_q.pop_front()));
        if (bus.mac_done) begin
          done_cnt++;
          check("mac_valid_per_frame", 32'(run_len), 32'(MAC_SIZE));
        end
      end else if (bus.mac_first || bus.mac_done) begin
        check("strobe_without_valid", 32'd1, 32'd0);
      end
    end
  end

  initial begin : main
    int low;
    int k;
    bus.s_valid = 1'b0;
    bus.c_load  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_strobes", 32'({bus.c_busy, bus.sample_we, bus.sample_en_0, bus.sample_en_1,
                              bus.coeff_en, bus.mac_valid, bus.mac_first, bus.mac_done, bus.overrun}), 32'd0);
    check("rst_addrs", 32'({bus.sample_addr, bus.coeff_addr}), 32'd0);
    check("rst_phase", 32'(bus.phase), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // one frame back-to-back, then count the not-ready window
    send_samples(D);
    #1;
    low = 0;
    while (!bus.s_ready && low < 30) begin
      low++;
      @(negedge clk);
      #1;
    end
    check("ready_low_cycles", 32'(low), 32'(MAC_SIZE + 1));

    // 11 more frames with s_valid held through each sweep: wp wraps repeatedly
    send_samples(D * 11);
    wait_idle();
    check("overrun_after_stream", 32'(bus.overrun), 32'(OVR_EN));

    // c_load and s_valid together in IDLE mid-frame
    send_samples(2);
    bus.c_load  = 1'b1;
    bus.s_valid = 1'b1;
    #1;
    check("collide_s_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    bus.c_load  = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    check("collide_c_busy", 32'(bus.c_busy), 32'd1);
    check("collide_phase", 32'(bus.phase), 32'd2);
    @(negedge clk);
    #1;
    check("collide_exit_busy", 32'(bus.c_busy), 32'd0);
    check("collide_exit_phase", 32'(bus.phase), 32'd2);
    send_samples(2);
    wait_idle();

    // c_load raised during the sweep is deferred until after mac_done
    send_samples(D);
    bus.c_load = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!bus.c_busy && k < 30);
    check("load_entered", 32'(bus.c_busy), 32'd1);
    check("load_after_done", 32'(done_cnt), 32'(exp_frames));
    check("load_coeff_en", 32'(bus.coeff_en), 32'd1);
    check("load_s_ready", 32'(bus.s_ready), 32'd0);
    repeat (2) @(negedge clk);
    bus.c_load = 1'b0;
    @(negedge clk);
    #1;
    check("load_exit_busy", 32'(bus.c_busy), 32'd0);
    check("load_exit_ready", 32'(bus.s_ready), 32'd1);
    check("load_exit_phase", 32'(bus.phase), 32'd0);
    check("overrun_sticky", 32'(bus.overrun), 32'(OVR_EN));

    // reset in the middle of a sweep: no mac_done, back to IDLE
    send_samples(D);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrun_rst_mac", 32'({bus.mac_valid, bus.mac_first, bus.mac_done}), 32'd0);
    check("midrun_rst_en", 32'({bus.sample_en_0, bus.sample_en_1, bus.coeff_en}), 32'd0);
    check("midrun_rst_ready", 32'(bus.s_ready), 32'd1);
    check("midrun_rst_overrun", 32'(bus.overrun), 32'd0);
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_mac_q.delete();
    n_acc = 0;
    exp_frames--;

    // recovery frame restarts at address 0, bank 0
    send_samples(D);
    wait_idle();
    repeat (2) @(negedge clk);

    check("frames_done", 32'(done_cnt), 32'(exp_frames));
    check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
    check("mac_q_drained", 32'(exp_mac_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
